// File: rtl/uart_fifo_unit.sv
// uart_fifo_unit: memory-mapped UART with run-time baud divisor, parity/stop options, TX/RX FIFOs, sticky errors and level irq
module uart_fifo_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h40000018,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter logic [15:0] DIV_RESET = 16'd26
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        out,
    input  logic        in,
    output logic        irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

    logic sel_txd, sel_rxd, sel_con, sel_baud, con_wr;
    logic [4:0]  con;
    logic [15:0] div, tick_cnt;
    logic        tick, ov, pe, fe, set_ov, set_pe, set_fe;
    logic [31:0] con_rd;
    logic        unused_wdata;

    logic [7:0]  tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp;
    logic        tx_empty, tx_full, tx_push, tx_pop, tx_busy;
    logic [7:0]  tx_head;
    tx_state_t   tx_st, tx_nx;
    logic [7:0]  tx_sh, tx_sh_nx;
    logic [3:0]  tx_tcnt, tx_tcnt_nx;
    logic [2:0]  tx_bcnt, tx_bcnt_nx;
    logic        tx_scnt, tx_scnt_nx, tx_par_en, tx_par_en_nx, tx_par_bit, tx_par_bit_nx;
    logic        tx_two, tx_two_nx, tx_bit_end, tx_load;

    logic [7:0]  rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wp, rx_rp;
    logic        rx_empty, rx_full, rx_push, rx_pop, rx_wr;
    logic [1:0]  sync;
    logic        rx_s, rx_samp;
    rx_state_t   rx_st, rx_nx;
    logic [7:0]  rx_sh, rx_sh_nx;
    logic [3:0]  rx_tcnt, rx_tcnt_nx;
    logic [2:0]  rx_bcnt, rx_bcnt_nx;

    assign sel_txd  = addr == BASE_ADDR;
    assign sel_rxd  = addr == BASE_ADDR + 32'd4;
    assign sel_con  = addr == BASE_ADDR + 32'd8;
    assign sel_baud = addr == BASE_ADDR + 32'd12;
    assign con_wr   = wr & sel_con;
    assign unused_wdata = ^wdata[31:16];

    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
    assign tx_push  = wr & sel_txd & ~tx_full;
    assign tx_head  = tx_mem[tx_rp[TAW-1:0]];
    assign tx_busy  = tx_st != T_IDLE;

    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
    assign rx_pop   = rd & sel_rxd & ~rx_empty;
    assign rx_wr    = rx_push & (~rx_full | rx_pop);
    assign set_ov   = rx_push & rx_full & ~rx_pop;
    assign rx_s     = sync[1];

    assign tick   = tick_cnt == div;
    assign con_rd = {16'b0, fe, pe, ov, rx_full, ~rx_empty, tx_busy, tx_empty, tx_full, 3'b0, con};
    assign rdata  = !rd ? 32'b0 :
                    sel_rxd ? {24'b0, rx_empty ? 8'b0 : rx_mem[rx_rp[RAW-1:0]]} :
                    sel_con ? con_rd :
                    sel_baud ? {16'b0, div} : 32'b0;
    assign out = tx_st == T_START ? 1'b0 :
                 tx_st == T_DATA  ? tx_sh[0] :
                 tx_st == T_PAR   ? tx_par_bit : 1'b1;

    // Control register, baud divisor and write-1-to-clear error flags (a new error wins over a clear)
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) begin
            con <= 5'b0;
            div <= DIV_RESET;
            ov  <= 1'b0;
            pe  <= 1'b0;
            fe  <= 1'b0;
        end else begin
            if (con_wr) con <= wdata[4:0];
            if (wr && sel_baud) div <= wdata[15:0];
            ov <= set_ov | (ov & ~(con_wr & wdata[13]));
            pe <= set_pe | (pe & ~(con_wr & wdata[14]));
            fe <= set_fe | (fe & ~(con_wr & wdata[15]));
        end

    // Oversampling tick divider; a divisor write restarts the count
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) tick_cnt <= 16'b0;
        else tick_cnt <= (wr && sel_baud) || tick ? 16'b0 : tick_cnt + 16'd1;

    // FIFO storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= wdata[7:0];
        if (rx_wr) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;
    end

    // FIFO pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            tx_wp <= tx_wp + {{TAW{1'b0}}, tx_push};
            tx_rp <= tx_rp + {{TAW{1'b0}}, tx_pop};
            rx_wp <= rx_wp + {{RAW{1'b0}}, rx_wr};
            rx_rp <= rx_rp + {{RAW{1'b0}}, rx_pop};
        end

    // TX state and shift datapath; frame format is latched when a byte is loaded
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) begin
            tx_st      <= T_IDLE;
            tx_sh      <= 8'b0;
            tx_tcnt    <= 4'b0;
            tx_bcnt    <= 3'b0;
            tx_scnt    <= 1'b0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_two     <= 1'b0;
        end else begin
            tx_st      <= tx_nx;
            tx_sh      <= tx_sh_nx;
            tx_tcnt    <= tx_tcnt_nx;
            tx_bcnt    <= tx_bcnt_nx;
            tx_scnt    <= tx_scnt_nx;
            tx_par_en  <= tx_par_en_nx;
            tx_par_bit <= tx_par_bit_nx;
            tx_two     <= tx_two_nx;
        end

    // TX next state: each bit lasts 16 ticks; STOP chains straight into START when data waits
    always_comb begin
        tx_nx         = tx_st;
        tx_sh_nx      = tx_sh;
        tx_tcnt_nx    = tx_tcnt;
        tx_bcnt_nx    = tx_bcnt;
        tx_scnt_nx    = tx_scnt;
        tx_par_en_nx  = tx_par_en;
        tx_par_bit_nx = tx_par_bit;
        tx_two_nx     = tx_two;
        tx_load       = 1'b0;
        tx_bit_end    = tick && tx_tcnt == 4'd15;
        if (tick && tx_st != T_IDLE) tx_tcnt_nx = tx_tcnt + 4'd1;
        case (tx_st)
            T_IDLE:  tx_load = tick & ~tx_empty;
            T_START: if (tx_bit_end) begin
                tx_nx      = T_DATA;
                tx_bcnt_nx = 3'd0;
            end
            T_DATA:  if (tx_bit_end) begin
                tx_sh_nx   = tx_sh >> 1;
                tx_bcnt_nx = tx_bcnt + 3'd1;
                tx_scnt_nx = 1'b0;
                if (tx_bcnt == 3'd7) tx_nx = tx_par_en ? T_PAR : T_STOP;
            end
            T_PAR:   if (tx_bit_end) begin
                tx_nx      = T_STOP;
                tx_scnt_nx = 1'b0;
            end
            T_STOP:  if (tx_bit_end) begin
                if (tx_two && !tx_scnt) tx_scnt_nx = 1'b1;
                else if (!tx_empty) tx_load = 1'b1;
                else tx_nx = T_IDLE;
            end
            default: tx_nx = T_IDLE;
        endcase
        if (tx_load) begin
            tx_nx         = T_START;
            tx_sh_nx      = tx_head;
            tx_tcnt_nx    = 4'd0;
            tx_par_en_nx  = con[3] ^ con[2];
            tx_par_bit_nx = ^tx_head ^ con[3];
            tx_two_nx     = con[4];
        end
    end
    assign tx_pop = tx_load;

    // RX line synchroniser, state and shift register
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) begin
            sync    <= 2'b11;
            rx_st   <= R_IDLE;
            rx_sh   <= 8'b0;
            rx_tcnt <= 4'b0;
            rx_bcnt <= 3'b0;
        end else begin
            sync    <= {sync[0], in};
            rx_st   <= rx_nx;
            rx_sh   <= rx_sh_nx;
            rx_tcnt <= rx_tcnt_nx;
            rx_bcnt <= rx_bcnt_nx;
        end

    // RX next state: sample 8 ticks after start detection, then every 16 ticks; config is live
    always_comb begin
        rx_nx      = rx_st;
        rx_sh_nx   = rx_sh;
        rx_tcnt_nx = rx_tcnt;
        rx_bcnt_nx = rx_bcnt;
        rx_push    = 1'b0;
        set_pe     = 1'b0;
        set_fe     = 1'b0;
        rx_samp    = tick && rx_tcnt == 4'd7;
        if (tick && rx_st != R_IDLE) rx_tcnt_nx = rx_tcnt + 4'd1;
        case (rx_st)
            R_IDLE:  if (tick && !rx_s) begin
                rx_nx      = R_START;
                rx_tcnt_nx = 4'd0;
            end
            R_START: if (rx_samp) begin
                rx_nx      = rx_s ? R_IDLE : R_DATA;
                rx_bcnt_nx = 3'd0;
            end
            R_DATA:  if (rx_samp) begin
                rx_sh_nx   = {rx_s, rx_sh[7:1]};
                rx_bcnt_nx = rx_bcnt + 3'd1;
                if (rx_bcnt == 3'd7) rx_nx = con[3] ^ con[2] ? R_PAR : R_STOP;
            end
            R_PAR:   if (rx_samp) begin
                set_pe = rx_s != (^rx_sh ^ con[3]);
                rx_nx  = R_STOP;
            end
            R_STOP:  if (rx_samp) begin
                set_fe  = ~rx_s;
                rx_push = 1'b1;
                rx_nx   = R_IDLE;
            end
            default: rx_nx = R_IDLE;
        endcase
    end

    // Registered level interrupt
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) irq <= 1'b0;
        else irq <= (con[0] & tx_empty & ~tx_busy) | (con[1] & ~rx_empty);
endmodule

// File: tb/tb_uart_fifo_unit.sv
// tb_uart_fifo_unit: directed checks of TX framing, FIFOs, RX errors, irq and async reset
module tb_uart_fifo_unit;
    localparam logic [31:0] TXD  = 32'h40000018;
    localparam logic [31:0] RXD  = 32'h4000001C;
    localparam logic [31:0] CON  = 32'h40000020;
    localparam logic [31:0] BAUD = 32'h40000024;

    logic        CLK = 1'b0, Reset_n = 1'b0, rd = 1'b0, wr = 1'b0, drv = 1'b1, loopback = 1'b0;
    logic [31:0] addr = 32'b0, wdata = 32'b0, rdata;
    logic        out, irq, in_line;
    int          checks = 0, failures = 0;

    always #5 CLK = ~CLK;
    assign in_line = loopback ? out : drv;

    uart_fifo_unit dut (
        .CLK(CLK), .Reset_n(Reset_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .out(out), .in(in_line), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bwr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge CLK);
        wr = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        addr = a; rd = 1'b1;
        #1 v = rdata;
        rd = 1'b0;
    endtask

    task automatic bpop(input logic [31:0] a, output logic [31:0] v);
        addr = a; rd = 1'b1;
        #1 v = rdata;
        @(negedge CLK);
        rd = 1'b0;
    endtask

    task automatic wait_low(input string tag);
        for (int k = 0; k < 200 && out !== 1'b0; k++) cyc(1);
        check(tag, {31'b0, out}, 32'd0);
    endtask

    task automatic send(input logic [7:0] d, input logic par_en, input logic par_bit, input logic stop);
        drv = 1'b0; cyc(16);
        for (int i = 0; i < 8; i++) begin
            drv = d[i]; cyc(16);
        end
        if (par_en) begin
            drv = par_bit; cyc(16);
        end
        drv = stop; cyc(16);
        drv = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        logic [9:0]  fr;
        logic [7:0]  b55;
        b55 = 8'h55;
        cyc(2);
        check("rst_out", {31'b0, out}, 32'd1);
        check("rst_irq", {31'b0, irq}, 32'd0);
        peek(CON, v);  check("rst_con", v, 32'h200);
        peek(BAUD, v); check("rst_baud", v, 32'd26);
        peek(RXD, v);  check("rst_rxd", v, 32'd0);
        Reset_n = 1'b1;
        cyc(1);
        addr = CON;
        #1 check("rdata_idle", rdata, 32'd0);

        bwr(BAUD, 32'd0);
        bwr(TXD, 32'h55);
        wait_low("t1_start");
        for (int k = 0; k <= 160; k++) begin
            if (k == 15) check("t1_start_end", {31'b0, out}, 32'd0);
            if (k == 16) check("t1_bit0_edge", {31'b0, out}, 32'd1);
            if (k % 16 == 8 && k / 16 >= 1 && k / 16 <= 8) check("t1_bit", {31'b0, out}, {31'b0, b55[k/16-1]});
            if (k == 152) check("t1_stop", {31'b0, out}, 32'd1);
            if (k == 159) begin peek(CON, v); check("t1_busy_hi", {31'b0, v[10]}, 32'd1); end
            if (k == 160) begin peek(CON, v); check("t1_busy_lo", {31'b0, v[10]}, 32'd0); end
            cyc(1);
        end

        bwr(CON, 32'h1);
        bwr(BAUD, 32'd1000);
        for (int i = 1; i <= 9; i++) bwr(TXD, i);
        peek(CON, v); check("t2_full", {31'b0, v[8]}, 32'd1);
        bwr(BAUD, 32'd0);
        wait_low("t2_start");
        for (int f = 0; f < 8; f++) begin
            fr = 10'b0;
            for (int k = 0; k < 160; k++) begin
                if (k % 16 == 8) fr[k/16] = out;
                if (f == 3 && k == 80) check("t2_irq_busy", {31'b0, irq}, 32'd0);
                cyc(1);
            end
            check("t2_frame", {22'b0, fr}, {22'b0, 1'b1, 8'(f + 1), 1'b0});
        end
        peek(CON, v); check("t2_idle", {29'b0, v[10:8]}, 32'b010);
        cyc(1);
        check("t2_irq", {31'b0, irq}, 32'd1);
        bwr(CON, 32'h0);

        bwr(CON, 32'h4);
        loopback = 1'b1;
        bwr(TXD, 32'hA5);
        v = 32'b0;
        for (int k = 0; k < 400 && !v[11]; k++) begin cyc(1); peek(CON, v); end
        check("t3_avail", {31'b0, v[11]}, 32'd1);
        bpop(RXD, v); check("t3_rxd", v, 32'hA5);
        peek(CON, v); check("t3_pe0", {30'b0, v[14], v[11]}, 32'd0);
        cyc(40);
        loopback = 1'b0;
        send(8'hA5, 1'b1, 1'b1, 1'b1);
        cyc(4);
        peek(CON, v); check("t3_pe1", {31'b0, v[14]}, 32'd1);
        bpop(RXD, v); check("t3_rxd_bad", v, 32'hA5);
        bwr(CON, 32'hE004);
        peek(CON, v); check("t3_clear", v, 32'h204);

        bwr(CON, 32'h2);
        for (int i = 0; i < 9; i++) send(8'h30 + 8'(i), 1'b0, 1'b0, 1'b1);
        cyc(4);
        peek(CON, v); check("t4_flags", {29'b0, v[13:11]}, 32'b111);
        check("t4_irq", {31'b0, irq}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            bpop(RXD, v); check("t4_rd", v, 32'h30 + i);
        end
        bpop(RXD, v); check("t4_empty_rd", v, 32'd0);
        peek(CON, v); check("t4_after", {30'b0, v[12:11]}, 32'd0);
        bwr(CON, 32'h2000);
        cyc(1);
        check("t4_irq_lo", {31'b0, irq}, 32'd0);
        peek(CON, v); check("t4_ov_clr", v, 32'h200);

        drv = 1'b0; cyc(4); drv = 1'b1;
        cyc(40);
        peek(CON, v); check("t5_glitch", {31'b0, v[11]}, 32'd0);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        cyc(4);
        peek(CON, v); check("t5_fe", {31'b0, v[15]}, 32'd1);
        bpop(RXD, v); check("t5_rxd", v, 32'h3C);
        cyc(40);
        peek(CON, v); check("t5_nobyte", {31'b0, v[11]}, 32'd0);
        bwr(CON, 32'h8000);

        send(8'h77, 1'b0, 1'b0, 1'b1);
        cyc(4);
        bwr(CON, 32'h1F);
        bwr(TXD, 32'h81);
        wait_low("t6_start");
        cyc(20);
        check("t6_irq_pre", {31'b0, irq}, 32'd1);
        #2 Reset_n = 1'b0;
        #1 check("t6_out", {31'b0, out}, 32'd1);
        check("t6_irq", {31'b0, irq}, 32'd0);
        peek(CON, v);  check("t6_con", v, 32'h200);
        peek(BAUD, v); check("t6_baud", v, 32'd26);
        peek(RXD, v);  check("t6_rxd", v, 32'd0);
        cyc(2);
        Reset_n = 1'b1;
        cyc(2);
        check("t6_out_idle", {31'b0, out}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
